cpu_data_memory: RTL and testbench
==================================

Name: cpu_data_memory

Overview:
- 64x8 data/program memory: responder side of the CPU memory bus (adr_bus, rd_mem, wr_mem, 8-bit data in each direction).
- After reset it clears its contents, then takes a byte-stream image over a valid/ready load port, then serves CPU reads and writes.
- Replaces file-fed stimulus on the CPU data input. The system holds the CPU in reset until ld_done is high.

Parameters:
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W = 64 words.
- DATA_W, 8, word width.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after every reset; 0 = keep contents and go straight to LOAD.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- adr_bus  in  ADDR_W  CPU word address.
- rd_mem  in  1  CPU read strobe, sampled each rising edge.
- wr_mem  in  1  CPU write strobe, sampled each rising edge.
- data_in  in  DATA_W  CPU write data (CPU d_out).
- data_out  out  DATA_W  read data to CPU (CPU d_in).
- rd_valid  out  1  one-cycle pulse: data_out was updated by a read.
- busy  out  1  high in CLEAR and LOAD.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_W  loader byte.
- ld_last  in  1  marks the final loader byte; qualified by ld_valid.
- ld_ready  out  1  memory accepts a loader byte this cycle.
- ld_done  out  1  image loaded; sticky until reset.
- ld_count  out  ADDR_W+1  number of loader bytes accepted (0..64).

Behaviour:
- Reset (reset=0, async) forces:
  - data_out=0, rd_valid=0, busy=1, ld_ready=0, ld_done=0, ld_count=0;
  - internal pointer=0;
  - state=CLEAR if CLEAR_ON_RESET, else LOAD.
- Reset asserted mid-operation aborts any clear, load or access immediately. A partially loaded image is cleared (CLEAR_ON_RESET=1) or kept (CLEAR_ON_RESET=0).
- CLEAR:
  - writes 0 to mem[pointer] each cycle and increments pointer;
  - after writing address 63: pointer=0, state=LOAD;
  - takes exactly 64 cycles; CPU strobes and ld_valid are ignored.
- LOAD:
  - ld_ready=1 combinationally in this state.
  - Transfer = ld_valid&ld_ready at a rising edge: mem[pointer]=ld_data, pointer+1, ld_count+1.
  - Transfer with ld_last=1, or transfer of the 64th byte: next state RUN, ld_done=1, busy=0, ld_ready=0 from the next cycle.
  - ld_last without ld_valid has no effect.
  - ld_count saturates at 64. The pointer never wraps into previously loaded bytes.
  - CPU strobes are ignored.
- RUN:
  - wr_mem=1: mem[adr_bus]=data_in at the edge.
  - rd_mem=1: data_out=mem[adr_bus] registered at the edge; rd_valid=1 for exactly that following cycle.
  - Read latency is 1 cycle. Back-to-back reads give back-to-back valid data.
  - rd_mem&wr_mem in the same cycle: write-first; data_out gets data_in and the memory is written.
  - A read in the cycle after a write to the same address returns the new value.
  - No read: data_out holds its last value; rd_valid=0.
  - ld_valid is ignored; ld_ready=0; ld_count frozen.
- Addresses are always in range (6 bits = 64 words), so there is no out-of-range case.
- State encoding: CLEAR, LOAD, RUN. No transition out of RUN except reset.

Test Plan:
- Clear: preload mem[5]=8'hAA via LOAD, finish load, assert reset, load 1 byte 8'h11 with ld_last → RUN; read adr 5 → data_out=8'h00 one cycle later, rd_valid pulse of width 1. Also check busy high for exactly 64 cycles after reset release.
- Load stream: 3 bytes 8'h01,8'h02,8'h03 with gaps in ld_valid, last on the third → ld_count=3, ld_done=1, busy=0. Reads of adr 0,1,2 back-to-back → 8'h01,8'h02,8'h03 on consecutive cycles.
- Full load: 64 bytes (value = address), ld_last never asserted → RUN after the 64th byte, ld_count=64, ld_ready=0. A 65th ld_valid is ignored and mem[0] stays 8'h00.
- CPU write/read: wr_mem adr 6'd63 data 8'h5C, then rd_mem adr 63 → data_out=8'h5C. rd_mem&wr_mem adr 10 data 8'hE7 → data_out=8'hE7 next cycle.
- Strobe gating: rd_mem/wr_mem during CLEAR and LOAD → no memory change, rd_valid=0, data_out stays 8'h00.
- Async reset mid-load (after 2 of 4 bytes, between clock edges) → outputs return to reset values immediately without a clock edge. With CLEAR_ON_RESET=0, mem[0..1] retained and visible after the next load completes.

Source files
------------

// File: rtl/cpu_data_memory.sv
// 64x8 CPU data/program memory: zero-fill after reset, byte-stream image load,
// then single-cycle-latency CPU reads and writes from the responder side of the bus.
module cpu_data_memory #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam state_t ST_AFTER_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              out_live_q, out_live_d;

  logic              mem_we, mem_re;
  logic              mem_we_en, mem_re_en;
  logic [ADDR_W-1:0] mem_wadr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    done_d     = done_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    out_live_d = out_live_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_wadr   = ptr_q;
    mem_wdata  = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + 1'b1;
          if (count_q != COUNT_FULL) begin
            count_d = count_q + 1'b1;
          end
          // Leaving on the 64th byte keeps the wrapped pointer from ever reusing address 0.
          if (ld_last || (ptr_q == PTR_LAST)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (wr_mem) begin
          mem_we    = 1'b1;
          mem_wadr  = adr_bus;
          mem_wdata = data_in;
        end
        if (rd_mem) begin
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
          out_live_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_AFTER_RESET;
      end
    endcase
  end

  // The array has no reset of its own, so hold off every access while reset is low.
  assign mem_we_en = mem_we && reset;
  assign mem_re_en = mem_re && reset;

  always_ff @(posedge clk) begin
    if (mem_we_en) begin
      mem[mem_wadr] <= mem_wdata;
    end
    if (mem_re_en) begin
      mem_rd_q <= mem_we_en ? mem_wdata : mem[adr_bus];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_AFTER_RESET;
      ptr_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      out_live_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      out_live_q <= out_live_d;
    end
  end

  // Read data stays at zero after reset until the first real read lands in mem_rd_q.
  assign data_out = out_live_q ? mem_rd_q : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign ld_ready = (state_q == ST_LOAD) && reset;
  assign ld_done  = done_q;
  assign ld_count = count_q;

endmodule

// File: tb/tb_cpu_data_memory.sv
// Bench for cpu_data_memory: clear/load/run sequences, a vector table of CPU accesses
// and a read-data scoreboard; a second instance covers contents kept across reset.
module tb_cpu_data_memory;

  logic       clk;
  logic       reset0, reset1;
  logic [5:0] adr_bus;
  logic       rd_mem, wr_mem;
  logic [7:0] data_in;
  logic       ld_valid, ld_last;
  logic [7:0] ld_data;

  logic [7:0] data_out0, data_out1;
  logic       rd_valid0, rd_valid1;
  logic       busy0, busy1;
  logic       ld_ready0, ld_ready1;
  logic       ld_done0, ld_done1;
  logic [6:0] ld_count0, ld_count1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rd;
    logic       wr;
    logic [5:0] adr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  cpu_data_memory dut0 (
    .clk(clk), .reset(reset0), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in(data_in), .data_out(data_out0), .rd_valid(rd_valid0), .busy(busy0),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready0),
    .ld_done(ld_done0), .ld_count(ld_count0)
  );

  cpu_data_memory #(.CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset(reset1), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in(data_in), .data_out(data_out1), .rd_valid(rd_valid1), .busy(busy1),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready1),
    .ld_done(ld_done1), .ld_count(ld_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gap cycles present ld_last (optionally) without ld_valid, which must do nothing.
  task automatic load_byte(input logic [7:0] d, input logic last, input int gap, input logic gap_last);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_last  = gap_last;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (!ld_ready0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [5:0] adr,
                        input logic [7:0] din, input logic [7:0] exp);
    rd_mem  = rd;
    wr_mem  = wr;
    adr_bus = adr;
    data_in = din;
    if (rd) exp_q.push_back(exp);
    tick();
  endtask

  task automatic cpu_idle(input int n);
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Scoreboard: every rd_valid pulse from dut0 must match the oldest expected read.
  always @(negedge clk) begin
    if (reset0 && rd_valid0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_spurious: rd_valid=1 data_out=%0h with no read pending at %0t", data_out0, $time);
      end else begin
        check("rd_data", {24'd0, data_out0}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;

    vecs[0] = '{rd: 1'b0, wr: 1'b1, adr: 6'd63, din: 8'h5C, exp: 8'h00};
    vecs[1] = '{rd: 1'b1, wr: 1'b0, adr: 6'd63, din: 8'h00, exp: 8'h5C};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, adr: 6'd10, din: 8'hE7, exp: 8'hE7};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, adr: 6'd10, din: 8'h00, exp: 8'hE7};
    vecs[4] = '{rd: 1'b1, wr: 1'b0, adr: 6'd20, din: 8'h00, exp: 8'h14};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, adr: 6'd1,  din: 8'h00, exp: 8'h01};
    vecs[6] = '{rd: 1'b1, wr: 1'b0, adr: 6'd2,  din: 8'h00, exp: 8'h02};
    vecs[7] = '{rd: 1'b0, wr: 1'b1, adr: 6'd33, din: 8'hC3, exp: 8'h00};
    vecs[8] = '{rd: 1'b1, wr: 1'b0, adr: 6'd33, din: 8'h00, exp: 8'hC3};
    vecs[9] = '{rd: 1'b1, wr: 1'b0, adr: 6'd0,  din: 8'h00, exp: 8'h00};

    reset0 = 1'b0; reset1 = 1'b0;
    adr_bus = '0; rd_mem = 1'b0; wr_mem = 1'b0; data_in = '0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    #12;
    check("rst_data_out", data_out0, 0);
    check("rst_rd_valid", rd_valid0, 0);
    check("rst_busy", busy0, 1);
    check("rst_ld_ready", ld_ready0, 0);
    check("rst_ld_done", ld_done0, 0);
    check("rst_ld_count", ld_count0, 0);
    check("rst_ld_ready_noclr", ld_ready1, 0);

    // Phase A: put AA at address 5, reset, and confirm the clear wiped it.
    tick();
    reset0 = 1'b1;
    wait_clear(n);
    check("clear_cycles_first", n, 64);
    for (int i = 0; i < 5; i++) load_byte(8'h00, 1'b0, 0, 1'b0);
    load_byte(8'hAA, 1'b1, 0, 1'b0);
    check("preload_done", ld_done0, 1);
    check("preload_count", ld_count0, 6);
    reset0 = 1'b0;
    #2;
    reset0 = 1'b1;
    wait_clear(n);
    check("clear_cycles", n, 64);
    check("busy_in_load", busy0, 1);
    load_byte(8'h11, 1'b1, 0, 1'b0);
    check("one_byte_done", ld_done0, 1);
    cpu_op(1'b1, 1'b0, 6'd5, 8'h00, 8'h00);
    rd_mem = 1'b0;
    check("rd_valid_pulse", rd_valid0, 1);
    tick();
    check("rd_valid_width", rd_valid0, 0);
    cpu_op(1'b1, 1'b0, 6'd0, 8'h00, 8'h11);
    cpu_idle(2);

    // Phase B: CPU strobes held high through clear and load must be ignored.
    reset0 = 1'b0;
    #2;
    reset0 = 1'b1;
    rd_mem = 1'b1; wr_mem = 1'b1; adr_bus = 6'd7; data_in = 8'h77;
    wait_clear(n);
    check("clear_cycles_strobed", n, 64);
    load_byte(8'h01, 1'b0, 2, 1'b1);
    load_byte(8'h02, 1'b0, 1, 1'b1);
    load_byte(8'h03, 1'b1, 3, 1'b0);
    rd_mem = 1'b0; wr_mem = 1'b0;
    check("stream_count", ld_count0, 3);
    check("stream_done", ld_done0, 1);
    check("stream_busy", busy0, 0);
    check("stream_ld_ready", ld_ready0, 0);
    check("gated_data_out", data_out0, 0);
    check("gated_rd_valid", rd_valid0, 0);
    cpu_op(1'b1, 1'b0, 6'd0, 8'h00, 8'h01);
    cpu_op(1'b1, 1'b0, 6'd1, 8'h00, 8'h02);
    cpu_op(1'b1, 1'b0, 6'd2, 8'h00, 8'h03);
    cpu_op(1'b1, 1'b0, 6'd7, 8'h00, 8'h00);
    cpu_idle(2);

    // Phase C: full 64-byte image without ld_last, then the vector table.
    reset0 = 1'b0;
    #2;
    reset0 = 1'b1;
    wait_clear(n);
    for (int i = 0; i < 64; i++) load_byte(8'(i), 1'b0, 0, 1'b0);
    check("full_count", ld_count0, 64);
    check("full_ld_ready", ld_ready0, 0);
    check("full_done", ld_done0, 1);
    load_byte(8'hFF, 1'b0, 0, 1'b0);
    check("extra_byte_count", ld_count0, 64);
    for (int i = 0; i < 10; i++) begin
      cpu_op(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].din, vecs[i].exp);
    end
    cpu_idle(3);
    check("count_frozen", ld_count0, 64);
    check("scoreboard_drained", exp_q.size(), 0);

    // Phase D: contents kept across an async reset in the middle of a load.
    reset0 = 1'b0;
    tick();
    reset1 = 1'b1;
    #1;
    check("noclr_ready_at_once", ld_ready1, 1);
    load_byte(8'hA1, 1'b0, 0, 1'b0);
    load_byte(8'hA2, 1'b0, 0, 1'b0);
    check("noclr_partial_count", ld_count1, 2);
    ld_valid = 1'b1; ld_data = 8'hA3;
    #3;
    reset1 = 1'b0;
    #1;
    check("async_ld_count", ld_count1, 0);
    check("async_ld_ready", ld_ready1, 0);
    check("async_busy", busy1, 1);
    check("async_ld_done", ld_done1, 0);
    check("async_rd_valid", rd_valid1, 0);
    check("async_data_out", data_out1, 0);
    ld_valid = 1'b0;
    tick();
    tick();
    reset1 = 1'b1;
    #1;
    check("noclr_reload_ready", ld_ready1, 1);
    load_byte(8'hB0, 1'b1, 0, 1'b0);
    check("noclr_reload_done", ld_done1, 1);
    check("noclr_reload_count", ld_count1, 1);
    rd_mem = 1'b1; adr_bus = 6'd1;
    tick();
    check("noclr_kept_valid", rd_valid1, 1);
    check("noclr_kept_data", data_out1, 8'hA2);
    adr_bus = 6'd0;
    tick();
    check("noclr_new_data", data_out1, 8'hB0);
    rd_mem = 1'b0;
    tick();
    check("noclr_rd_valid_low", rd_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
